// File: rtl/interest_parser.sv
// Byte-serial interest packet parser: validates the header, assembles the name into a left-aligned prefix, and holds it for the PIT stage.
// Optional statistics counters are enabled by defining INTEREST_PARSER_STATS_EN.
module interest_parser #(
  parameter logic [7:0] INTEREST_TYPE  = 8'h05,
  parameter int         MAX_NAME_BYTES = 8,
  parameter int         STAT_W         = 16,
  localparam int        PREFIX_W       = 8 * MAX_NAME_BYTES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [7:0]          in_data,
  output logic                in_ready,
  output logic [PREFIX_W-1:0] prefix,
  output logic [5:0]          len,
  output logic                prefix_ready,
  input  logic                pit_ack,
  output logic [STAT_W-1:0]   accept_cnt,
  output logic [STAT_W-1:0]   drop_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LEN      = 3'd1,
    ST_NAME     = 3'd2,
    ST_HOLD     = 3'd3,
    ST_DROP_LEN = 3'd4,
    ST_DROP     = 3'd5
  } state_t;

  localparam logic [7:0] MAX_LEN = 8'(MAX_NAME_BYTES);

  state_t              state_r, state_nxt_s;
  logic                run_r;
  logic                xfer_s;
  logic                len_ok_s;
  logic                last_byte_s;
  logic [5:0]          byte_idx_r;
  logic [7:0]          skip_cnt_r;
  logic [PREFIX_W-1:0] prefix_r;
  logic [5:0]          len_r;
  logic                prefix_ready_r;

  // run_r keeps in_ready low until the first clock after reset release
  assign in_ready    = run_r && (state_r != ST_HOLD);
  assign xfer_s      = in_valid && in_ready;
  assign len_ok_s    = (in_data != 8'd0) && (in_data <= MAX_LEN);
  assign last_byte_s = (byte_idx_r == (len_r - 6'd1));

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (xfer_s) state_nxt_s = (in_data == INTEREST_TYPE) ? ST_LEN : ST_DROP_LEN;
        else        state_nxt_s = state_r;
      end
      ST_LEN: begin
        if (xfer_s) begin
          if (len_ok_s)               state_nxt_s = ST_NAME;
          else if (in_data == 8'd0)   state_nxt_s = ST_IDLE;
          else                        state_nxt_s = ST_DROP;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_NAME: begin
        if (xfer_s && last_byte_s) state_nxt_s = ST_HOLD;
        else                       state_nxt_s = state_r;
      end
      ST_HOLD: begin
        if (pit_ack) state_nxt_s = ST_IDLE;
        else         state_nxt_s = state_r;
      end
      ST_DROP_LEN: begin
        if (xfer_s) state_nxt_s = (in_data == 8'd0) ? ST_IDLE : ST_DROP;
        else        state_nxt_s = state_r;
      end
      ST_DROP: begin
        if (xfer_s && (skip_cnt_r == 8'd1)) state_nxt_s = ST_IDLE;
        else                                state_nxt_s = state_r;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      run_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      run_r   <= 1'b1;
    end
  end

  // Name assembly, skip counter and presentation flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_idx_r     <= 6'd0;
      skip_cnt_r     <= 8'd0;
      prefix_r       <= {PREFIX_W{1'b0}};
      len_r          <= 6'd0;
      prefix_ready_r <= 1'b0;
    end else begin
      prefix_ready_r <= (state_nxt_s == ST_HOLD);
      case (state_r)
        ST_LEN: begin
          if (xfer_s && len_ok_s) begin
            len_r      <= in_data[5:0];
            prefix_r   <= {PREFIX_W{1'b0}};
            byte_idx_r <= 6'd0;
          end else if (xfer_s && (in_data != 8'd0)) begin
            skip_cnt_r <= in_data;
          end
        end
        ST_NAME: begin
          if (xfer_s) begin
            for (int i = 0; i < MAX_NAME_BYTES; i++) begin
              if (byte_idx_r == 6'(i)) prefix_r[PREFIX_W-1-8*i -: 8] <= in_data;
            end
            byte_idx_r <= byte_idx_r + 6'd1;
          end
        end
        ST_DROP_LEN: begin
          if (xfer_s) skip_cnt_r <= in_data;
        end
        ST_DROP: begin
          if (xfer_s) skip_cnt_r <= skip_cnt_r - 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign prefix       = prefix_r;
  assign len          = len_r;
  assign prefix_ready = prefix_ready_r;

`ifdef INTEREST_PARSER_STATS_EN
  logic [STAT_W-1:0] accept_cnt_r, drop_cnt_r;
  logic              accept_evt_s, drop_evt_s;

  assign accept_evt_s = (state_r == ST_HOLD) && pit_ack;
  assign drop_evt_s   = xfer_s && (((state_r == ST_IDLE) && (in_data != INTEREST_TYPE)) ||
                                   ((state_r == ST_LEN) && !len_ok_s));

  // Saturating packet counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accept_cnt_r <= {STAT_W{1'b0}};
      drop_cnt_r   <= {STAT_W{1'b0}};
    end else begin
      if (accept_evt_s && (accept_cnt_r != {STAT_W{1'b1}}))
        accept_cnt_r <= accept_cnt_r + {{(STAT_W-1){1'b0}}, 1'b1};
      if (drop_evt_s && (drop_cnt_r != {STAT_W{1'b1}}))
        drop_cnt_r <= drop_cnt_r + {{(STAT_W-1){1'b0}}, 1'b1};
    end
  end

  assign accept_cnt = accept_cnt_r;
  assign drop_cnt   = drop_cnt_r;
`else
  assign accept_cnt = {STAT_W{1'b0}};
  assign drop_cnt   = {STAT_W{1'b0}};
`endif

endmodule
